riscv_core_dcache_controller: RTL
=================================

// Module: riscv_core_dcache_controller
// PURPOSE
//  Sequencing FSM for the direct-mapped L1 data cache: holds the tag/valid/dirty arrays,
//  decides hit/miss, drives the read/write/AMO/replace enables of the dcache data memory,
//  and requests write-back and refill from the AXI block. Sits between the core LSU and
//  the dcache data memory / AXI interface.
// PARAMETERS
//  ADDR_WIDTH   64  core byte-address width
//  INDEX_WIDTH  7   set index bits, addr[11:5]; 128 lines
//  TAG_WIDTH    52  tag bits, addr[63:12]; 32-byte lines, addr[4:0] offset
// PORTS
//  i_clk                 in   1           clock
//  i_rst_n               in   1           asynchronous, active-low reset
//  i_req_valid           in   1           core memory request; held stable while o_stall=1
//  i_req_wr              in   1           1 = store, 0 = load
//  i_req_amo             in   1           atomic read-modify-write; overrides i_req_wr
//  i_addr                in   ADDR_WIDTH  request byte address
//  o_stall               out  1           core must hold request this cycle
//  o_mem_rd_en           out  1           data memory read enable
//  o_mem_wr_en           out  1           data memory write enable
//  o_mem_amo_wr          out  1           data memory writes AMO ALU result
//  o_mem_block_replace   out  1           data memory writes full AXI block
//  o_axi_rd_req          out  1           refill request, level, held until i_axi_rd_done
//  o_axi_wr_req          out  1           write-back request, level, held until i_axi_wr_done
//  o_axi_addr            out  ADDR_WIDTH  line address for AXI, bits [4:0] = 0
//  i_axi_rd_done         in   1           1-cycle pulse: refill block valid on AXI data bus
//  i_axi_wr_done         in   1           1-cycle pulse: victim line accepted
// BEHAVIOUR
//  - Reset: state IDLE; all valid and dirty bits 0; all outputs 0. Tags are not reset.
//  - Lookup is combinational in IDLE: hit = valid[idx] && tag[idx]==i_addr[63:12].
//  - States: IDLE, WRITEBACK, REFILL, AMO_WR.
//  - IDLE, !i_req_valid: all outputs 0.
//  - IDLE, load hit: o_mem_rd_en=1, o_stall=0. Zero added latency.
//  - IDLE, store hit: o_mem_wr_en=1, o_stall=0. Set dirty[idx] at the clock edge.
//  - IDLE, AMO hit: o_mem_rd_en=1, o_stall=1, go to AMO_WR.
//    AMO_WR: o_mem_wr_en=1, o_mem_amo_wr=1, o_stall=0; set dirty; go to IDLE.
//    An AMO therefore costs 2 cycles.
//  - IDLE, miss, line clean or invalid: o_stall=1, go to REFILL.
//  - IDLE, miss, valid and dirty: o_stall=1, go to WRITEBACK.
//  - WRITEBACK: o_axi_wr_req=1, o_axi_addr={tag[idx],idx,5'b0}, o_stall=1.
//    On i_axi_wr_done: clear dirty[idx], go to REFILL.
//  - REFILL: o_axi_rd_req=1, o_axi_addr={i_addr[63:5],5'b0}, o_stall=1.
//    On the i_axi_rd_done cycle: o_mem_wr_en=1, o_mem_block_replace=1; write tag;
//    valid=1, dirty=0; go to IDLE.
//    The request replays in IDLE the next cycle and hits (miss = hit latency + AXI + 1).
//  - The o_axi_rd_req and o_axi_wr_req requests are never asserted together.
//  - A done pulse received outside the matching state is ignored.
//  - Enables are mutually exclusive, except wr_en together with amo_wr or with block_replace.
//  - Reset asserted mid-WRITEBACK or mid-REFILL: the transaction is abandoned. Requests
//    drop asynchronously and all lines become invalid.
//  - i_req_valid deasserted while o_stall=1 is illegal (bench assertion).
// CONFIGURATION
//  DCACHE_PERF_CNT_EN defined: adds outputs o_hit_cnt[31:0] and o_miss_cnt[31:0].
//    Each counter increments once per IDLE lookup. The hit replay after a refill is
//    not counted. Counters wrap at 2^32 and reset to 0.
//  DCACHE_PERF_CNT_EN undefined: the ports and counters are absent.
// TESTING
//  1. After reset, load 0x1000 -> REFILL, o_axi_addr=0x1000. rd_done -> wr_en+replace.
//     Next cycle rd_en=1, stall=0.
//  2. Store 0x1008 to a valid line -> same-cycle wr_en=1, stall=0; dirty[0] becomes 1.
//  3. Dirty idx 0 with tag 0x1, load 0x2000 -> WRITEBACK with o_axi_addr=0x1000.
//     Then REFILL with o_axi_addr=0x2000. Then hit.
//  4. AMO hit at 0x2010 -> cycle 1 rd_en=1, stall=1; cycle 2 wr_en=1, amo_wr=1, stall=0.
//  5. Reset pulsed during REFILL -> o_axi_rd_req=0 immediately; the next load to the
//     same address misses again.
//  6. DCACHE_PERF_CNT_EN: tests 1-4 -> o_hit_cnt=2, o_miss_cnt=2.

Source files
------------

// File: rtl/riscv_core_dcache_controller.sv
// Direct-mapped L1 dcache sequencer: tag/valid/dirty arrays, hit/miss decision,
// data-memory enables and AXI write-back/refill requests. Optional DCACHE_PERF_CNT_EN adds hit/miss counters.
module riscv_core_dcache_controller #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INDEX_WIDTH = 7,
  parameter int unsigned TAG_WIDTH   = 52
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  input  logic                  i_req_wr,
  input  logic                  i_req_amo,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_stall,
  output logic                  o_mem_rd_en,
  output logic                  o_mem_wr_en,
  output logic                  o_mem_amo_wr,
  output logic                  o_mem_block_replace,
  output logic                  o_axi_rd_req,
  output logic                  o_axi_wr_req,
  output logic [ADDR_WIDTH-1:0] o_axi_addr,
  input  logic                  i_axi_rd_done,
  input  logic                  i_axi_wr_done
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]           o_hit_cnt,
  output logic [31:0]           o_miss_cnt
`endif
);

  localparam int unsigned OFFSET_WIDTH = ADDR_WIDTH - INDEX_WIDTH - TAG_WIDTH;
  localparam int unsigned LINES        = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, AMO_WR} state_t;

  state_t                 state_q, state_d;
  logic [LINES-1:0]       valid_q, dirty_q;
  logic [TAG_WIDTH-1:0]   tag_q [LINES];
  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   hit;
  logic                   set_dirty, clr_dirty, refill_we;
  logic                   unused_offset;

  assign idx           = i_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag       = i_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign hit           = valid_q[idx] && (tag_q[idx] == req_tag);
  assign unused_offset = ^i_addr[OFFSET_WIDTH-1:0];

  // Next state and combinational enables; the core sees hit results in the request cycle.
  always_comb begin
    state_d             = state_q;
    o_stall             = 1'b0;
    o_mem_rd_en         = 1'b0;
    o_mem_wr_en         = 1'b0;
    o_mem_amo_wr        = 1'b0;
    o_mem_block_replace = 1'b0;
    o_axi_rd_req        = 1'b0;
    o_axi_wr_req        = 1'b0;
    o_axi_addr          = '0;
    set_dirty           = 1'b0;
    clr_dirty           = 1'b0;
    refill_we           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          if (hit) begin
            if (i_req_amo) begin
              o_mem_rd_en = 1'b1;
              o_stall     = 1'b1;
              state_d     = AMO_WR;
            end else if (i_req_wr) begin
              o_mem_wr_en = 1'b1;
              set_dirty   = 1'b1;
            end else begin
              o_mem_rd_en = 1'b1;
            end
          end else begin
            o_stall = 1'b1;
            state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        o_stall      = 1'b1;
        o_axi_wr_req = 1'b1;
        o_axi_addr   = {tag_q[idx], idx, OFFSET_WIDTH'(0)};
        if (i_axi_wr_done) begin
          clr_dirty = 1'b1;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        o_stall      = 1'b1;
        o_axi_rd_req = 1'b1;
        o_axi_addr   = {i_addr[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'(0)};
        if (i_axi_rd_done) begin
          o_mem_wr_en         = 1'b1;
          o_mem_block_replace = 1'b1;
          refill_we           = 1'b1;
          state_d             = IDLE;
        end
      end
      AMO_WR: begin
        o_mem_wr_en  = 1'b1;
        o_mem_amo_wr = 1'b1;
        set_dirty    = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and line status; reset invalidates every line and abandons AXI traffic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (refill_we) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (set_dirty) begin
        dirty_q[idx] <= 1'b1;
      end else if (clr_dirty) begin
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Tag storage is not reset; valid bits gate its use.
  always_ff @(posedge i_clk) begin
    if (refill_we) tag_q[idx] <= req_tag;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic        replay_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // One count per fresh lookup; the replay right after a refill is skipped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      replay_q <= (state_q == REFILL) && i_axi_rd_done;
      if ((state_q == IDLE) && i_req_valid && !replay_q) begin
        if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
        else     miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`else
  // Build without performance counters: nothing further to instantiate.
`endif

endmodule
